// File: rtl/relu_maxpool2x2_if.sv
// Pixel stream bundle: a valid qualifier plus CO packed channels.
// Used for both the conv-side input and the pooled output.
interface relu_maxpool2x2_if #(
    parameter int W = 72
) ();
    logic         valid;
    logic [W-1:0] fmap;

    modport master (output valid, output fmap);
    modport slave  (input  valid, input  fmap);
endinterface

// File: rtl/relu_maxpool2x2.sv
// Per-channel ReLU followed by 2x2 stride-2 max pooling on a raster-order pixel stream.
// state    | meaning
// ROW_EVEN | top row of a pooling window: horizontal maxima go into the row buffer
// ROW_ODD  | bottom row: combine with the buffered maxima and emit a pooled pixel
module relu_maxpool2x2 #(
    parameter int CO     = 3,
    parameter int I_F_BW = 24,
    parameter int IX     = 24,
    parameter int IY     = 24,
    parameter int O_F_BW = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    relu_maxpool2x2_if.slave       i_in,
    relu_maxpool2x2_if.master      o_ot,
    output logic                   o_ot_last
);

    localparam int W  = CO * I_F_BW;
    localparam int XW = (IX > 1) ? $clog2(IX) : 1;
    localparam int YW = (IY > 1) ? $clog2(IY) : 1;
    localparam int CW = (IX / 2 > 1) ? $clog2(IX / 2) : 1;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [W-1:0]        r_pair;
    logic [W-1:0]        r_rowbuf [IX/2];
    logic                r_ot_valid;
    logic                r_ot_last;
    logic [CO*O_F_BW-1:0] r_ot_fmap;

    logic [W-1:0]        w_relu;
    logic [W-1:0]        w_hmax;
    logic [W-1:0]        w_vmax;
    logic [W-1:0]        w_rd;
    logic [CW-1:0]       w_col;
    logic                w_x_last;
    logic                w_y_last;
    logic                w_x_odd;
    logic                w_wr_en;
    logic                w_pool_en;

    assign w_x_last = (r_x == XW'(IX - 1));
    assign w_y_last = (r_y == YW'(IY - 1));
    assign w_x_odd  = r_x[0];
    assign w_col    = CW'(r_x >> 1);
    assign w_rd     = r_rowbuf[w_col];

    always_comb begin
        w_relu = '0;
        for (int c = 0; c < CO; c++) begin
            w_relu[c*I_F_BW +: I_F_BW] = i_in.fmap[c*I_F_BW + I_F_BW - 1] ? '0
                                       : i_in.fmap[c*I_F_BW +: I_F_BW];
        end
    end

    // Post-ReLU operands are non-negative, so an unsigned compare is exact.
    always_comb begin
        w_hmax = '0;
        for (int c = 0; c < CO; c++) begin
            w_hmax[c*I_F_BW +: I_F_BW] =
                (r_pair[c*I_F_BW +: I_F_BW] > w_relu[c*I_F_BW +: I_F_BW])
                ? r_pair[c*I_F_BW +: I_F_BW] : w_relu[c*I_F_BW +: I_F_BW];
        end
    end

    always_comb begin
        w_vmax = '0;
        for (int c = 0; c < CO; c++) begin
            w_vmax[c*I_F_BW +: I_F_BW] =
                (w_rd[c*I_F_BW +: I_F_BW] > w_hmax[c*I_F_BW +: I_F_BW])
                ? w_rd[c*I_F_BW +: I_F_BW] : w_hmax[c*I_F_BW +: I_F_BW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ROW_EVEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_pool_en   = 1'b0;
        case (r_state)
            ROW_EVEN: begin
                w_wr_en = i_in.valid & w_x_odd;
                if (i_in.valid && w_x_last) begin
                    w_state_nxt = ROW_ODD;
                end
            end
            ROW_ODD: begin
                w_pool_en = i_in.valid & w_x_odd;
                if (i_in.valid && w_x_last) begin
                    w_state_nxt = ROW_EVEN;
                end
            end
            default: w_state_nxt = ROW_EVEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pair <= '0;
        end else if (i_in.valid) begin
            if (!w_x_odd) begin
                r_pair <= w_relu;
            end
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Buffer is always rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_rowbuf[w_col] <= w_hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ot_valid <= 1'b0;
            r_ot_last  <= 1'b0;
            r_ot_fmap  <= '0;
        end else begin
            r_ot_valid <= w_pool_en;
            r_ot_last  <= w_pool_en & w_x_last & w_y_last;
            if (w_pool_en) begin
                r_ot_fmap <= w_vmax;
            end
        end
    end

    assign o_ot.valid = r_ot_valid;
    assign o_ot.fmap  = r_ot_fmap;
    assign o_ot_last  = r_ot_last;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Random and directed stimulus for a 4x4 and a 24x24 instance, checked against a
// frame-level ReLU + 2x2 max-pool reference kept in the bench.
module tb_relu_maxpool2x2;

    localparam int CO = 3;
    localparam int BW = 24;
    localparam int W  = CO * BW;

    typedef struct {
        logic [W-1:0] val;
        logic         last;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;
    logic last_s, last_d;

    relu_maxpool2x2_if #(.W(W)) if_s_in ();
    relu_maxpool2x2_if #(.W(W)) if_s_ot ();
    relu_maxpool2x2_if #(.W(W)) if_d_in ();
    relu_maxpool2x2_if #(.W(W)) if_d_ot ();

    relu_maxpool2x2 #(.CO(CO), .I_F_BW(BW), .IX(4), .IY(4), .O_F_BW(BW)) dut_s (
        .clk(clk), .reset(reset), .i_in(if_s_in), .o_ot(if_s_ot), .o_ot_last(last_s)
    );

    relu_maxpool2x2 #(.CO(CO), .I_F_BW(BW), .IX(24), .IY(24), .O_F_BW(BW)) dut_d (
        .clk(clk), .reset(reset), .i_in(if_d_in), .o_ot(if_d_ot), .o_ot_last(last_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           m_x [2];
    int           m_y [2];
    logic [W-1:0] m_frm [2][24][24];
    logic [W-1:0] held [2];
    exp_t         q0 [$];
    exp_t         q1 [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int dim(input int sel);
        return (sel == 0) ? 4 : 24;
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [BW-1:0] p;
        p = BW'(v);
        return {p, p, p};
    endfunction

    // Max over the 2x2 window whose bottom-right pixel is (x, y), after ReLU.
    function automatic logic [W-1:0] pool_ref(input int sel, input int x, input int y);
        logic [W-1:0]  res;
        logic [BW-1:0] best, v;
        res = '0;
        for (int c = 0; c < CO; c++) begin
            best = '0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    v = m_frm[sel][y-1+dy][x-1+dx][c*BW +: BW];
                    if (!v[BW-1] && v > best) best = v;
                end
            end
            res[c*BW +: BW] = best;
        end
        return res;
    endfunction

    task automatic px(input int sel, input bit v, input logic [W-1:0] d);
        exp_t e;
        int   n;
        n = dim(sel);
        @(negedge clk);
        if_s_in.valid = 1'b0;
        if_d_in.valid = 1'b0;
        if (sel == 0) begin
            if_s_in.valid = v;
            if_s_in.fmap  = d;
        end else begin
            if_d_in.valid = v;
            if_d_in.fmap  = d;
        end
        if (v) begin
            m_frm[sel][m_y[sel]][m_x[sel]] = d;
            if ((m_x[sel] % 2 == 1) && (m_y[sel] % 2 == 1)) begin
                e.val  = pool_ref(sel, m_x[sel], m_y[sel]);
                e.last = (m_x[sel] == n - 1) && (m_y[sel] == n - 1);
                e.cyc  = cyc + 1;
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
            end
            if (m_x[sel] == n - 1) begin
                m_x[sel] = 0;
                m_y[sel] = (m_y[sel] == n - 1) ? 0 : m_y[sel] + 1;
            end else begin
                m_x[sel]++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) px(0, 1'b0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        if_s_in.valid = 1'b0;
        if_d_in.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_x[0] = 0; m_y[0] = 0;
        m_x[1] = 0; m_y[1] = 0;
    endtask

    task automatic drain(input string tag);
        idle(3);
        check({tag, "_pending_s"}, W'(q0.size()), '0);
        check({tag, "_pending_d"}, W'(q1.size()), '0);
    endtask

    task automatic mon(input int sel, input bit rs, input logic v, input logic [W-1:0] f,
                       input logic l);
        exp_t  e;
        string s;
        s = (sel == 0) ? "s" : "d";
        if (rs) begin
            check({s, "_rst_valid"}, W'(v), '0);
            check({s, "_rst_fmap"}, f, '0);
            check({s, "_rst_last"}, W'(l), '0);
            held[sel] = '0;
            return;
        end
        if (v) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                check({s, "_unexpected_pulse"}, W'(v), '0);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                check({s, "_pool_val"}, f, e.val);
                check({s, "_pool_last"}, W'(l), W'(e.last));
                check({s, "_pool_cyc"}, W'(cyc), W'(e.cyc));
                held[sel] = e.val;
            end
        end else begin
            check({s, "_idle_last"}, W'(l), '0);
            check({s, "_hold_fmap"}, f, held[sel]);
        end
    endtask

    always @(posedge clk) begin
        bit rs;
        rs = reset;
        cyc++;
        #1;
        mon(0, rs, if_s_ot.valid, if_s_ot.fmap, last_s);
        mon(1, rs, if_d_ot.valid, if_d_ot.fmap, last_d);
    end

    initial begin
        logic [BW-1:0] c0, c1, c2;
        reset = 1'b1;
        if_s_in.valid = 1'b0;
        if_s_in.fmap  = '0;
        if_d_in.valid = 1'b0;
        if_d_in.fmap  = '0;
        held[0] = '0; held[1] = '0;
        m_x[0] = 0; m_y[0] = 0;
        m_x[1] = 0; m_y[1] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // ramp frame: expect 5, 7, 13, 15
        for (int i = 0; i < 16; i++) px(0, 1'b1, rep(i));
        drain("ramp");

        // ReLU: negative inputs clip to zero
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                c0 = (x == 1 && y == 1) ? BW'(9) : BW'(-3);
                c1 = BW'(-1);
                c2 = BW'(2);
                px(0, 1'b1, {c2, c1, c0});
            end
        end
        drain("relu");

        // valid gaps: fixed 1,0,0 pattern then random gap lengths
        for (int i = 0; i < 16; i++) begin
            px(0, 1'b1, rep(i));
            if (i < 6) idle(2);
            else       idle($urandom_range(0, 3));
        end
        drain("gaps");

        // back-to-back frames
        for (int i = 0; i < 16; i++) px(0, 1'b1, rep(i));
        for (int i = 0; i < 16; i++) px(0, 1'b1, rep(100 + i));
        drain("b2b");

        // reset mid-frame, then a clean frame
        for (int i = 0; i < 9; i++) px(0, 1'b1, rep(i));
        idle(2);
        pulse_reset();
        idle(1);
        for (int i = 0; i < 16; i++) px(0, 1'b1, rep(i));
        drain("midrst");

        // random signed frames with random gaps on the small instance
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                px(0, 1'b1, {BW'($urandom), BW'($urandom), BW'($urandom)});
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain("rand_s");

        // full-size instance: one continuous random frame
        for (int i = 0; i < 576; i++) begin
            px(1, 1'b1, {BW'($urandom), BW'($urandom), BW'($urandom)});
        end
        drain("rand_d");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
